vm_ctrl_param: RTL and testbench

- Parametrised next-generation vending controller: N_ITEMS product slots, per-slot stock and price registers, coin credit accumulation, change return, cancel/refund and an inactivity timeout.
- Sits between the user panel (coins, buttons, select, cancel), the supplier restock port (item, count, cost, valid) and the dispenser/coin-return mechanics (product, product_valid, balance, change_valid).

---
 rtl/vm_ctrl_param.sv | 235 +++++++++++++++++++++++
 tb/tb_vm_ctrl_param.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vm_ctrl_param.sv
// Parametrised vending controller: per-slot stock and price storage,
// coin credit collection with inactivity timeout, dispense with change
// and cancel/soft-reset refunds. Every output is driven straight from a flop.
module vm_ctrl_param #(
    parameter int N_ITEMS = 8,
    parameter int CNT_W   = 4,
    parameter int COST_W  = 8,
    parameter int BAL_W   = 16,
    parameter int TIMEOUT = 512,
    localparam int IW     = $clog2(N_ITEMS)
) (
    input  logic              clk,
    input  logic              hrst_n,
    input  logic              srst,
    input  logic [1:0]        coins,
    input  logic [IW-1:0]     buttons,
    input  logic              select,
    input  logic              cancel,
    input  logic [IW-1:0]     item,
    input  logic [CNT_W-1:0]  count,
    input  logic [COST_W-1:0] cost,
    input  logic              valid,
    output logic [IW-1:0]     product,
    output logic              product_valid,
    output logic [1:0]        status,
    output logic [BAL_W-1:0]  balance,
    output logic              change_valid,
    output logic [7:0]        info
);

    // Storage covers every encodable index so out-of-range lookups read a
    // never-written (always zero) entry instead of indexing past the array.
    localparam int              NSLOT      = 1 << IW;
    localparam int              TW         = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TMR_RELOAD = TW'(TIMEOUT - 1);
    localparam logic [IW:0]     N_LIM      = (IW + 1)'(N_ITEMS);

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_AVAIL = 2'b01;
    localparam logic [1:0] ST_OOS   = 2'b10;
    localparam logic [1:0] ST_ERR   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESTOCK,
        S_COLLECT,
        S_DISPENSE,
        S_REFUND
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      sel_q, sel_d;
    logic [BAL_W-1:0]   credit_q, credit_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [CNT_W-1:0]   stock_q [NSLOT];
    logic [CNT_W-1:0]   stock_d [NSLOT];
    logic [COST_W-1:0]  price_q [NSLOT];
    logic [COST_W-1:0]  price_d [NSLOT];
    logic [IW-1:0]      product_q, product_d;
    logic               product_valid_q, product_valid_d;
    logic [1:0]         status_q, status_d;
    logic [BAL_W-1:0]   balance_q, balance_d;
    logic               change_valid_q, change_valid_d;
    logic [7:0]         info_q, info_d;

    logic [BAL_W:0]     coin_val;
    logic [BAL_W:0]     credit_sum;
    logic [BAL_W-1:0]   credit_sat;
    logic [BAL_W-1:0]   price_sel;
    logic [CNT_W:0]     rs_sum;
    logic               item_ok;
    logic               btn_ok;

    // Coin value decode, saturating credit add and restock overflow sum.
    always_comb begin
        coin_val = '0;
        case (coins)
            2'b01:   coin_val = (BAL_W + 1)'(5);
            2'b10:   coin_val = (BAL_W + 1)'(10);
            2'b11:   coin_val = (BAL_W + 1)'(25);
            default: coin_val = '0;
        endcase
        credit_sum = {1'b0, credit_q} + coin_val;
        credit_sat = credit_sum[BAL_W] ? '1 : credit_sum[BAL_W-1:0];
        price_sel  = BAL_W'(price_q[sel_q]);
        rs_sum     = {1'b0, stock_q[item]} + {1'b0, count};
        item_ok    = ({1'b0, item} < N_LIM);
        btn_ok     = ({1'b0, buttons} < N_LIM);
    end

    // Next-state and registered-output computation; pulses default low.
    always_comb begin
        state_d         = state_q;
        sel_d           = sel_q;
        credit_d        = credit_q;
        timer_d         = timer_q;
        stock_d         = stock_q;
        price_d         = price_q;
        product_d       = product_q;
        product_valid_d = 1'b0;
        status_d        = status_q;
        balance_d       = balance_q;
        change_valid_d  = 1'b0;
        info_d          = info_q;

        if (srst) begin
            if (state_q == S_COLLECT) begin
                // Abort a purchase as a refund so the user gets the credit back.
                state_d        = S_REFUND;
                balance_d      = credit_q;
                change_valid_d = 1'b1;
                credit_d       = '0;
                status_d       = ST_OK;
            end else begin
                state_d   = S_IDLE;
                credit_d  = '0;
                timer_d   = '0;
                product_d = '0;
                status_d  = ST_OK;
                balance_d = '0;
                info_d    = '0;
            end
        end else begin
            case (state_q)
                S_IDLE, S_RESTOCK: begin
                    if (valid) begin
                        state_d = S_RESTOCK;
                        if (!item_ok || rs_sum[CNT_W]) begin
                            status_d = ST_ERR;
                        end else begin
                            stock_d[item] = rs_sum[CNT_W-1:0];
                            if (cost != '0) begin
                                price_d[item] = cost;
                            end
                            status_d = ST_OK;
                            info_d   = 8'(rs_sum[CNT_W-1:0]);
                        end
                    end else if (state_q == S_RESTOCK) begin
                        state_d = S_IDLE;
                    end else if (select) begin
                        sel_d = buttons;
                        if (!btn_ok || stock_q[buttons] == '0 || price_q[buttons] == '0) begin
                            status_d = ST_OOS;
                            info_d   = btn_ok ? 8'(stock_q[buttons]) : 8'd0;
                        end else begin
                            status_d  = ST_AVAIL;
                            info_d    = 8'(stock_q[buttons]);
                            credit_d  = '0;
                            balance_d = '0;
                            timer_d   = TMR_RELOAD;
                            state_d   = S_COLLECT;
                        end
                    end
                end
                S_COLLECT: begin
                    if (credit_q >= price_sel) begin
                        // Dispense outputs are presented during the DISPENSE cycle.
                        state_d         = S_DISPENSE;
                        product_d       = sel_q;
                        product_valid_d = 1'b1;
                        stock_d[sel_q]  = stock_q[sel_q] - CNT_W'(1);
                        info_d          = 8'(stock_q[sel_q] - CNT_W'(1));
                        balance_d       = credit_q - price_sel;
                        change_valid_d  = 1'b1;
                        credit_d        = '0;
                        status_d        = ST_OK;
                    end else if (cancel) begin
                        state_d        = S_REFUND;
                        balance_d      = credit_sat;
                        change_valid_d = 1'b1;
                        credit_d       = '0;
                        status_d       = ST_OK;
                    end else if (coins != 2'b00) begin
                        credit_d  = credit_sat;
                        balance_d = credit_sat;
                        timer_d   = TMR_RELOAD;
                    end else if (timer_q == '0) begin
                        state_d        = S_REFUND;
                        balance_d      = credit_q;
                        change_valid_d = 1'b1;
                        credit_d       = '0;
                        status_d       = ST_ERR;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                S_DISPENSE, S_REFUND: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, storage and output registers; hard reset wipes stock and prices too.
    always_ff @(posedge clk or negedge hrst_n) begin
        if (!hrst_n) begin
            state_q         <= S_IDLE;
            sel_q           <= '0;
            credit_q        <= '0;
            timer_q         <= '0;
            stock_q         <= '{default: '0};
            price_q         <= '{default: '0};
            product_q       <= '0;
            product_valid_q <= 1'b0;
            status_q        <= '0;
            balance_q       <= '0;
            change_valid_q  <= 1'b0;
            info_q          <= '0;
        end else begin
            state_q         <= state_d;
            sel_q           <= sel_d;
            credit_q        <= credit_d;
            timer_q         <= timer_d;
            stock_q         <= stock_d;
            price_q         <= price_d;
            product_q       <= product_d;
            product_valid_q <= product_valid_d;
            status_q        <= status_d;
            balance_q       <= balance_d;
            change_valid_q  <= change_valid_d;
            info_q          <= info_d;
        end
    end

    assign product       = product_q;
    assign product_valid = product_valid_q;
    assign status        = status_q;
    assign balance       = balance_q;
    assign change_valid  = change_valid_q;
    assign info          = info_q;

endmodule

// File: tb/tb_vm_ctrl_param.sv
// Self-checking bench for vm_ctrl_param: directed scenarios followed by
// randomized restock/purchase traffic, compared against a transaction-level
// model of slot stock, prices and the customer's credit.
module tb_vm_ctrl_param;

    localparam int N    = 6;
    localparam int CW   = 4;
    localparam int PW   = 8;
    localparam int BW   = 16;
    localparam int TO   = 16;
    localparam int IW   = 3;
    localparam int MAXC = 15;

    logic          clk = 1'b0;
    logic          hrst_n = 1'b0;
    logic          srst = 1'b0;
    logic [1:0]    coins = '0;
    logic [IW-1:0] buttons = '0;
    logic          select = 1'b0;
    logic          cancel = 1'b0;
    logic [IW-1:0] item = '0;
    logic [CW-1:0] count = '0;
    logic [PW-1:0] cost = '0;
    logic          valid = 1'b0;
    logic [IW-1:0] product;
    logic          product_valid;
    logic [1:0]    status;
    logic [BW-1:0] balance;
    logic          change_valid;
    logic [7:0]    info;

    vm_ctrl_param #(
        .N_ITEMS(N), .CNT_W(CW), .COST_W(PW), .BAL_W(BW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .hrst_n(hrst_n), .srst(srst), .coins(coins),
        .buttons(buttons), .select(select), .cancel(cancel),
        .item(item), .count(count), .cost(cost), .valid(valid),
        .product(product), .product_valid(product_valid), .status(status),
        .balance(balance), .change_valid(change_valid), .info(info)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: what the machine should remember, in customer terms.
    int stock_m [8];
    int price_m [8];
    int status_m, info_m, bal_m;
    int credit_m, idle_m, slot_m;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int coin_value(input int c);
        case (c)
            1:       return 5;
            2:       return 10;
            3:       return 25;
            default: return 0;
        endcase
    endfunction

    task automatic check_held(input string tag);
        check_eq({tag, "_status"}, status, status_m);
        check_eq({tag, "_info"}, info, info_m);
        check_eq({tag, "_bal"}, balance, bal_m);
    endtask

    task automatic model_hard_reset();
        for (int i = 0; i < 8; i++) begin
            stock_m[i] = 0;
            price_m[i] = 0;
        end
        status_m = 0; info_m = 0; bal_m = 0;
    endtask

    // One supplier update edge; select noise must lose to valid.
    task automatic restock_edge(input int it, input int cnt, input int cst, input bit sel_noise);
        valid = 1'b1; item = IW'(it); count = CW'(cnt); cost = PW'(cst);
        select = sel_noise; buttons = IW'($urandom_range(0, 7));
        tick();
        valid = 1'b0; select = 1'b0;
        if (it >= N || stock_m[it] + cnt > MAXC) begin
            status_m = 3;
        end else begin
            stock_m[it] += cnt;
            if (cst != 0) price_m[it] = cst;
            status_m = 0;
            info_m = stock_m[it];
        end
        $display("txn restock item=%0d count=%0d cost=%0d status=%0d info=%0d", it, cnt, cst, status, info);
        check_held("restock");
        check_eq("restock_pv", product_valid, 0);
    endtask

    // Cycle back to IDLE; a select here hits RESTOCK and must be ignored.
    task automatic restock_return(input bit sel_noise);
        select = sel_noise; buttons = IW'($urandom_range(0, 7));
        tick();
        select = 1'b0;
        check_held("rs_ret");
    endtask

    task automatic restock(input int it, input int cnt, input int cst);
        restock_edge(it, cnt, cst, 1'b0);
        restock_return(1'b0);
    endtask

    task automatic select_try(input int b, output bit ok);
        select = 1'b1; buttons = IW'(b);
        tick();
        select = 1'b0;
        ok = (b < N) && stock_m[b] > 0 && price_m[b] > 0;
        if (ok) begin
            status_m = 1; info_m = stock_m[b]; bal_m = 0;
            slot_m = b; credit_m = 0; idle_m = 0;
        end else begin
            status_m = 2; info_m = (b < N) ? stock_m[b] : 0;
        end
        $display("txn select button=%0d status=%0d info=%0d", b, status, info);
        check_held("select");
        check_eq("select_pv", product_valid, 0);
        check_eq("select_cv", change_valid, 0);
    endtask

    // One cycle in COLLECT with the given coin/cancel; done=1 when the
    // purchase ends (dispense or refund pulse visible now).
    task automatic collect_step(input int c, input bit cn, output bit done);
        coins = 2'(c); cancel = cn;
        tick();
        coins = '0; cancel = 1'b0;
        done = 1'b1;
        if (credit_m >= price_m[slot_m]) begin
            stock_m[slot_m]--;
            info_m = stock_m[slot_m];
            bal_m = credit_m - price_m[slot_m];
            status_m = 0;
            check_eq("disp_pv", product_valid, 1);
            check_eq("disp_prod", product, slot_m);
            check_eq("disp_cv", change_valid, 1);
            $display("txn dispense slot=%0d credit=%0d change=%0d", slot_m, credit_m, balance);
        end else if (cn) begin
            credit_m += coin_value(c);
            bal_m = credit_m; status_m = 0;
            check_eq("cancel_cv", change_valid, 1);
            check_eq("cancel_pv", product_valid, 0);
            $display("txn cancel refund=%0d", balance);
        end else if (c != 0) begin
            credit_m += coin_value(c);
            idle_m = 0; bal_m = credit_m; done = 1'b0;
            check_eq("coin_cv", change_valid, 0);
            check_eq("coin_pv", product_valid, 0);
        end else begin
            idle_m++;
            if (idle_m == TO) begin
                bal_m = credit_m; status_m = 3;
                check_eq("tmo_cv", change_valid, 1);
                check_eq("tmo_pv", product_valid, 0);
                $display("txn timeout refund=%0d", balance);
            end else begin
                done = 1'b0;
                check_eq("idle_cv", change_valid, 0);
            end
        end
        check_held("collect");
        if (done) credit_m = 0;
    endtask

    task automatic srst_collect();
        srst = 1'b1;
        tick();
        srst = 1'b0;
        bal_m = credit_m; status_m = 0; credit_m = 0;
        $display("txn srst-collect refund=%0d", balance);
        check_eq("srst_cv", change_valid, 1);
        check_eq("srst_pv", product_valid, 0);
        check_held("srst_col");
    endtask

    task automatic srst_idle();
        srst = 1'b1;
        tick();
        srst = 1'b0;
        status_m = 0; info_m = 0; bal_m = 0;
        $display("txn srst-idle status=%0d info=%0d", status, info);
        check_held("srst_idle");
        check_eq("srst_prod", product, 0);
    endtask

    // Cycle spent in DISPENSE/REFUND: coins, select and valid are all ignored.
    task automatic finish_txn();
        coins = 2'($urandom_range(0, 3)); select = 1'b1; buttons = IW'($urandom_range(0, 7));
        valid = 1'b1; item = IW'($urandom_range(0, N - 1)); count = CW'($urandom_range(1, 3));
        cancel = 1'b1;
        tick();
        coins = '0; select = 1'b0; valid = 1'b0; cancel = 1'b0;
        check_eq("post_pv", product_valid, 0);
        check_eq("post_cv", change_valid, 0);
        check_held("post");
    endtask

    task automatic purchase_random(input int b);
        bit ok, done, abandon;
        int guard;
        select_try(b, ok);
        if (ok) begin
            abandon = ($urandom_range(0, 7) == 0);
            done = 1'b0; guard = 0;
            while (!done && guard < 400) begin
                int r, c;
                bit cn;
                guard++;
                r = $urandom_range(0, 99);
                cn = !abandon && (r < 4);
                c = (abandon && guard > 1) ? 0 : ((r % 10) < 3 ? 0 : $urandom_range(1, 3));
                collect_step(c, cn, done);
            end
            check_eq("collect_done", done, 1);
            finish_txn();
        end
    endtask

    initial begin
        bit ok, done;
        model_hard_reset();
        #2;
        check_eq("rst_status", status, 0);
        check_eq("rst_info", info, 0);
        check_eq("rst_bal", balance, 0);
        check_eq("rst_prod", product, 0);
        check_eq("rst_pv", product_valid, 0);
        check_eq("rst_cv", change_valid, 0);
        #10 hrst_n = 1'b1;
        tick();

        // Restock, overflow rejection and invalid slot.
        restock(2, 5, 35);
        check_eq("rs_info5", info, 5);
        restock(2, 11, 0);
        restock(7, 1, 10);

        // Exact payment: quarter then dime.
        select_try(2, ok);
        collect_step(3, 1'b0, done);
        check_eq("bal25", balance, 25);
        collect_step(2, 1'b0, done);
        check_eq("bal35", balance, 35);
        collect_step(0, 1'b0, done);
        finish_txn();

        // Overpayment with change.
        select_try(2, ok);
        collect_step(3, 1'b0, done);
        collect_step(3, 1'b0, done);
        collect_step(0, 1'b0, done);
        finish_txn();

        // Empty slot and zero-price slot.
        select_try(3, ok);
        restock(4, 3, 0);
        select_try(4, ok);
        select_try(7, ok);

        // Inactivity timeout.
        select_try(2, ok);
        collect_step(1, 1'b0, done);
        for (int k = 0; k < TO + 4 && !done; k++) collect_step(0, 1'b0, done);
        check_eq("tmo_done", done, 1);
        finish_txn();

        // Cancel, then cancel with a coin in the same cycle.
        select_try(2, ok);
        collect_step(2, 1'b0, done);
        collect_step(0, 1'b1, done);
        finish_txn();
        select_try(2, ok);
        collect_step(2, 1'b0, done);
        collect_step(1, 1'b1, done);
        finish_txn();

        // Soft reset mid-purchase keeps stock; soft reset when idle clears outputs.
        select_try(2, ok);
        collect_step(3, 1'b0, done);
        srst_collect();
        finish_txn();
        select_try(2, ok);
        srst_collect();
        finish_txn();
        srst_idle();
        select_try(2, ok);
        srst_collect();
        finish_txn();

        // Randomized traffic.
        for (int t = 0; t < 60; t++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 3) begin
                int cst;
                cst = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 120);
                restock_edge($urandom_range(0, 7), $urandom_range(0, 8), cst, 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 2) == 0)
                    restock_edge($urandom_range(0, 7), $urandom_range(0, 6), $urandom_range(0, 120), 1'b0);
                restock_return(1'($urandom_range(0, 1)));
            end else if (r == 3) begin
                srst_idle();
            end else begin
                purchase_random($urandom_range(0, 7));
            end
        end

        // Hard reset asserted between edges mid-purchase.
        restock(1, 4, 20);
        select_try(1, ok);
        collect_step(2, 1'b0, done);
        #3 hrst_n = 1'b0;
        #1;
        model_hard_reset();
        check_eq("hrst_status", status, 0);
        check_eq("hrst_info", info, 0);
        check_eq("hrst_bal", balance, 0);
        check_eq("hrst_prod", product, 0);
        check_eq("hrst_pv", product_valid, 0);
        check_eq("hrst_cv", change_valid, 0);
        #12 hrst_n = 1'b1;
        tick();
        check_eq("hrst_cv2", change_valid, 0);
        select_try(1, ok);
        select_try(2, ok);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
